// File: rtl/mem_access_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_access_pkg                                                   |
// | Brief   : Pipeline-register structs, FSM state enum and access-size        |
// |           constants/helpers shared by the memory-access stage.             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package mem_access_pkg;

    localparam logic [2:0] C_F3_B  = 3'b000;
    localparam logic [2:0] C_F3_H  = 3'b001;
    localparam logic [2:0] C_F3_W  = 3'b010;
    localparam logic [2:0] C_F3_BU = 3'b100;
    localparam logic [2:0] C_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_RD = 2'd2
    } mem_fsm_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [2:0]  func3;
        logic [4:0]  rd;
        logic        we;
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic        misaligned;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_state_t;

    // Unsigned sizes are legal for loads only, so they fault for stores.
    function automatic logic access_misaligned(input logic [2:0] f3,
                                               input logic [1:0] off,
                                               input logic       store);
        logic r;
        case (f3)
            C_F3_B:  r = 1'b0;
            C_F3_H:  r = off[0];
            C_F3_W:  r = (off != 2'b00);
            C_F3_BU: r = store;
            C_F3_HU: r = store | off[0];
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [3:0] r;
        case (f3[1:0])
            2'b00:   r = 4'b0001 << off;
            2'b01:   r = 4'b0011 << off;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                               input logic [31:0] rs2);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{rs2[7:0]}};
            2'b01:   r = {2{rs2[15:0]}};
            default: r = rs2;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : load_align                                                       |
// | Brief   : Selects byte/half of a read word and sign/zero extends it.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_func3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_func3)
            C_F3_B:  o_data = {{24{w_byte[7]}}, w_byte};
            C_F3_H:  o_data = {{16{w_half[15]}}, w_half};
            C_F3_BU: o_data = {24'd0, w_byte};
            C_F3_HU: o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_access                                                       |
// | Brief   : MEM pipeline stage: issues data-memory loads/stores, aligns      |
// |           load data and produces a one-cycle MEM/WB result pulse.          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mem_access
    import mem_access_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_ALUOutput,
    input  logic [31:0] i_rs2,
    input  logic [2:0]  i_func3,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [4:0]  i_rd,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic        o_wb_we,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_misaligned
);

    mem_fsm_e   r_state;
    mem_fsm_e   w_state_next;
    mem_state_t r_mem;
    mem_state_t w_mem_next;
    wb_state_t  r_wb;
    wb_state_t  w_wb_next;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_misaligned;
    logic [31:0] w_load_data;

    // Load takes precedence if both class bits are set.
    assign w_is_load    = i_is_load;
    assign w_is_store   = i_is_store & ~i_is_load;
    assign w_misaligned = access_misaligned(i_func3, i_ALUOutput[1:0], w_is_store);

    load_align u_load_align (
        .i_rdata   (i_dmem_rdata),
        .i_addr_lo (r_mem.addr[1:0]),
        .i_func3   (r_mem.func3),
        .o_data    (w_load_data)
    );

    always_comb begin
        w_state_next = r_state;
        w_mem_next   = r_mem;
        w_wb_next    = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    if (!w_is_load && !w_is_store) begin
                        w_wb_next.valid = 1'b1;
                        w_wb_next.we    = (i_rd != 5'd0);
                        w_wb_next.rd    = i_rd;
                        w_wb_next.data  = i_ALUOutput;
                    end else if (w_misaligned) begin
                        w_wb_next.valid      = 1'b1;
                        w_wb_next.misaligned = 1'b1;
                        w_wb_next.rd         = i_rd;
                        w_wb_next.data       = i_ALUOutput;
                    end else begin
                        w_mem_next.addr  = i_ALUOutput;
                        w_mem_next.wdata = store_data(i_func3, i_rs2);
                        w_mem_next.be    = byte_enables(i_func3, i_ALUOutput[1:0]);
                        w_mem_next.func3 = i_func3;
                        w_mem_next.rd    = i_rd;
                        w_mem_next.we    = w_is_store;
                        w_state_next     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (i_dmem_gnt) begin
                    if (r_mem.we) begin
                        w_wb_next.valid = 1'b1;
                        w_wb_next.rd    = r_mem.rd;
                        w_state_next    = ST_IDLE;
                    end else begin
                        w_state_next = ST_WAIT_RD;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (i_dmem_rvalid) begin
                    w_wb_next.valid = 1'b1;
                    w_wb_next.we    = (r_mem.rd != 5'd0);
                    w_wb_next.rd    = r_mem.rd;
                    w_wb_next.data  = w_load_data;
                    w_state_next    = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_mem   <= '0;
            r_wb    <= '0;
        end else begin
            r_state <= w_state_next;
            r_mem   <= w_mem_next;
            r_wb    <= w_wb_next;
        end
    end

    assign o_ready      = (r_state == ST_IDLE);
    assign o_dmem_req   = (r_state == ST_REQ);
    assign o_dmem_we    = (r_state == ST_REQ) & r_mem.we;
    assign o_dmem_addr  = {r_mem.addr[31:2], 2'b00};
    assign o_dmem_be    = r_mem.be;
    assign o_dmem_wdata = r_mem.wdata;
    assign o_wb_valid   = r_wb.valid;
    assign o_wb_we      = r_wb.we;
    assign o_wb_rd      = r_wb.rd;
    assign o_wb_data    = r_wb.data;
    assign o_misaligned = r_wb.misaligned;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mem_access                                                    |
// | Brief   : Directed self-checking bench for mem_access.                     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [2:0]  func3;
    logic        is_load;
    logic        is_store;
    logic [4:0]  rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_valid       (valid),
        .o_ready       (ready),
        .i_ALUOutput   (alu),
        .i_rs2         (rs2),
        .i_func3       (func3),
        .i_is_load     (is_load),
        .i_is_store    (is_store),
        .i_rd          (rd),
        .o_dmem_req    (dmem_req),
        .o_dmem_we     (dmem_we),
        .o_dmem_addr   (dmem_addr),
        .o_dmem_be     (dmem_be),
        .o_dmem_wdata  (dmem_wdata),
        .i_dmem_gnt    (dmem_gnt),
        .i_dmem_rvalid (dmem_rvalid),
        .i_dmem_rdata  (dmem_rdata),
        .o_wb_valid    (wb_valid),
        .o_wb_we       (wb_we),
        .o_wb_rd       (wb_rd),
        .o_wb_data     (wb_data),
        .o_misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one entry for a single cycle, then scramble the inputs so that
    // any missing latching inside the DUT shows up in later checks.
    task automatic accept(input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, input logic ld, input logic st,
                          input logic [4:0] r);
        alu = a; rs2 = d; func3 = f; is_load = ld; is_store = st; rd = r;
        valid = 1'b1;
        cyc();
        valid = 1'b0;
        alu = 32'hDEAD_BEEF; rs2 = 32'h5555_AAAA; func3 = 3'b111;
        is_load = 1'b0; is_store = 1'b0; rd = 5'd31;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        n_checks++;
        if ({ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_dmem: got rdy=%b req=%b we=%b addr=%h be=%b wd=%h, want rdy=1 all-zero",
                     ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        end
        n_checks++;
        if ({wb_valid, wb_we, misaligned, wb_rd, wb_data} !== {3'b000, 5'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_wb: got v=%b we=%b mis=%b rd=%0d data=%h, want all zero",
                     wb_valid, wb_we, misaligned, wb_rd, wb_data);
        end
    endtask

    task automatic test_pass_through();
        logic [31:0] va [4] = '{32'h0000_1234, 32'h1111_0001, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [4:0]  vr [4] = '{5'd5, 5'd1, 5'd31, 5'd0};
        accept(va[0], 32'h0, 3'b010, 1'b0, 1'b0, vr[0]);
        n_checks++;
        if ({wb_valid, wb_we, misaligned, wb_rd, wb_data, dmem_req} !== {3'b110, 5'd5, 32'h0000_1234, 1'b0}) begin
            n_fail++;
            $display("FAIL pass_single: got v=%b we=%b mis=%b rd=%0d data=%h req=%b, want v=1 we=1 mis=0 rd=5 data=00001234 req=0",
                     wb_valid, wb_we, misaligned, wb_rd, wb_data, dmem_req);
        end
        // back-to-back: valid held high, one result per cycle
        for (int i = 1; i < 4; i++) begin
            alu = va[i]; rd = vr[i]; is_load = 1'b0; is_store = 1'b0; valid = 1'b1;
            cyc();
            n_checks++;
            if ({wb_valid, wb_we, wb_rd, wb_data, ready} !== {1'b1, (vr[i] != 5'd0), vr[i], va[i], 1'b1}) begin
                n_fail++;
                $display("FAIL pass_b2b[%0d]: got v=%b we=%b rd=%0d data=%h rdy=%b, want v=1 we=%b rd=%0d data=%h rdy=1",
                         i, wb_valid, wb_we, wb_rd, wb_data, ready, (vr[i] != 5'd0), vr[i], va[i]);
            end
        end
        valid = 1'b0;
        cyc();
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_pulse: got wb_valid=%b, want 0", wb_valid);
        end
    endtask

    // Store: gnt withheld for gnt_delay cycles, request must stay stable.
    task automatic test_store(input string nm, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] f, input int gnt_delay,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd);
        accept(a, d, f, 1'b0, 1'b1, 5'd9);
        for (int i = 0; i <= gnt_delay; i++) begin
            dmem_gnt = (i == gnt_delay);
            n_checks++;
            if ({ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid} !==
                {1'b0, 1'b1, 1'b1, exp_addr, exp_be, exp_wd, 1'b0}) begin
                n_fail++;
                $display("FAIL %s_req[%0d]: got rdy=%b req=%b we=%b addr=%h be=%b wd=%h wbv=%b, want rdy=0 req=1 we=1 addr=%h be=%b wd=%h wbv=0",
                         nm, i, ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid,
                         exp_addr, exp_be, exp_wd);
            end
            cyc();
        end
        dmem_gnt = 1'b0;
        n_checks++;
        if ({dmem_req, wb_valid, wb_we, misaligned, ready} !== 5'b01001) begin
            n_fail++;
            $display("FAIL %s_done: got req=%b wbv=%b we=%b mis=%b rdy=%b, want req=0 wbv=1 we=0 mis=0 rdy=1",
                     nm, dmem_req, wb_valid, wb_we, misaligned, ready);
        end
    endtask

    // Load: gnt immediately, rvalid `lat` cycles after the gnt edge.
    task automatic test_load(input string nm, input logic [31:0] a, input logic [2:0] f,
                             input logic [4:0] r, input logic [31:0] rdata, input int lat,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_data);
        accept(a, 32'h0, f, 1'b1, 1'b0, r);
        n_checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, ready} !== {1'b1, 1'b0, exp_addr, exp_be, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_req: got req=%b we=%b addr=%h be=%b rdy=%b, want req=1 we=0 addr=%h be=%b rdy=0",
                     nm, dmem_req, dmem_we, dmem_addr, dmem_be, ready, exp_addr, exp_be);
        end
        dmem_gnt = 1'b1;
        cyc();
        dmem_gnt = 1'b0;
        for (int i = 1; i < lat; i++) begin
            n_checks++;
            if ({dmem_req, ready, wb_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL %s_wait[%0d]: got req=%b rdy=%b wbv=%b, want 0 0 0",
                         nm, i, dmem_req, ready, wb_valid);
            end
            cyc();
        end
        dmem_rdata = rdata;
        dmem_rvalid = 1'b1;
        cyc();
        dmem_rvalid = 1'b0;
        dmem_rdata = 32'h0;
        n_checks++;
        if ({wb_valid, wb_we, misaligned, wb_rd, wb_data, ready} !== {1'b1, (r != 5'd0), 1'b0, r, exp_data, 1'b1}) begin
            n_fail++;
            $display("FAIL %s_data: got v=%b we=%b mis=%b rd=%0d data=%h rdy=%b, want v=1 we=%b mis=0 rd=%0d data=%h rdy=1",
                     nm, wb_valid, wb_we, misaligned, wb_rd, wb_data, ready, (r != 5'd0), r, exp_data);
        end
    endtask

    task automatic test_misaligned(input string nm, input logic [31:0] a, input logic [2:0] f,
                                   input logic ld);
        accept(a, 32'h0, f, ld, ~ld, 5'd7);
        n_checks++;
        if ({dmem_req, wb_valid, misaligned, wb_we, ready} !== 5'b01101) begin
            n_fail++;
            $display("FAIL %s: got req=%b wbv=%b mis=%b we=%b rdy=%b, want req=0 wbv=1 mis=1 we=0 rdy=1",
                     nm, dmem_req, wb_valid, misaligned, wb_we, ready);
        end
    endtask

    task automatic test_reset_wait_rd();
        accept(32'h0000_0300, 32'h0, 3'b010, 1'b1, 1'b0, 5'd4);
        dmem_gnt = 1'b1;
        cyc();
        dmem_gnt = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++;
        if ({ready, wb_valid, dmem_req} !== 3'b100) begin
            n_fail++;
            $display("FAIL rst_wait_abort: got rdy=%b wbv=%b req=%b, want 1 0 0", ready, wb_valid, dmem_req);
        end
        dmem_rdata = 32'h1234_5678;
        dmem_rvalid = 1'b1;
        cyc();
        dmem_rvalid = 1'b0;
        cyc();
        n_checks++;
        if ({ready, wb_valid, dmem_req} !== 3'b100) begin
            n_fail++;
            $display("FAIL rst_stale_rvalid: got rdy=%b wbv=%b req=%b, want 1 0 0", ready, wb_valid, dmem_req);
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; alu = '0; rs2 = '0; func3 = '0;
        is_load = 1'b0; is_store = 1'b0; rd = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        test_reset();
        test_pass_through();
        test_store("sb", 32'h0000_0103, 32'h0000_00AB, 3'b000, 2,
                   32'h0000_0100, 4'b1000, 32'hABAB_ABAB);
        test_store("sh", 32'h0000_0002, 32'h1234_5678, 3'b001, 0,
                   32'h0000_0000, 4'b1100, 32'h5678_5678);
        test_store("sw", 32'h0000_0010, 32'hCAFE_F00D, 3'b010, 1,
                   32'h0000_0010, 4'b1111, 32'hCAFE_F00D);
        test_load("lb",  32'h0000_0101, 3'b000, 5'd3, 32'h0000_8000, 1,
                  32'h0000_0100, 4'b0010, 32'hFFFF_FF80);
        test_load("lbu", 32'h0000_0101, 3'b100, 5'd3, 32'h0000_8000, 1,
                  32'h0000_0100, 4'b0010, 32'h0000_0080);
        test_load("lh",  32'h0000_0202, 3'b001, 5'd6, 32'hFFFE_0000, 4,
                  32'h0000_0200, 4'b1100, 32'hFFFF_FFFE);
        test_load("lhu", 32'h0000_0202, 3'b101, 5'd0, 32'hFFFE_0000, 2,
                  32'h0000_0200, 4'b1100, 32'h0000_FFFE);
        test_load("lw",  32'h0000_0040, 3'b010, 5'd8, 32'h8765_4321, 1,
                  32'h0000_0040, 4'b1111, 32'h8765_4321);
        test_misaligned("mis_lw",  32'h0000_0102, 3'b010, 1'b1);
        test_misaligned("mis_lh",  32'h0000_0001, 3'b001, 1'b1);
        test_misaligned("mis_ld3", 32'h0000_0000, 3'b011, 1'b1);
        test_misaligned("mis_sbu", 32'h0000_0000, 3'b100, 1'b0);
        test_reset_wait_rd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 i_clk  in  1  single clock; all state updates on rising edge.
REQ-002 i_reset  in  1  synchronous, active-high reset.
REQ-003 i_valid  in  1  EX/MEM entry valid this cycle.
REQ-004 o_ready  out  1  block can accept an entry; transfer occurs when i_valid & o_ready.
REQ-005 i_ALUOutput  in  32  ALU result; byte address for load/store.
REQ-006 i_rs2  in  32  store data.
REQ-007 i_func3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 i_is_load, i_is_store  in  1 each  op class; both 0 = pass-through.
REQ-009 i_rd  in  5  destination register.
REQ-010 o_dmem_req  out  1, o_dmem_we  out  1, o_dmem_addr  out  32, o_dmem_be  out  4, o_dmem_wdata  out  32: data-memory request.
REQ-011 i_dmem_gnt  in  1  request accepted; i_dmem_rvalid  in  1, i_dmem_rdata  in  32: read response.
REQ-012 o_wb_valid  out  1, o_wb_we  out  1, o_wb_rd  out  5, o_wb_data  out  32, o_misaligned  out  1: MEM/WB result.

Function
REQ-013 FSM states: IDLE, REQ, WAIT_RD; o_ready = 1 only in IDLE.
REQ-014 Pass-through accepted in IDLE: next cycle o_wb_valid=1, o_wb_we=(i_rd!=0), o_wb_data=i_ALUOutput; state stays IDLE; back-to-back accepts every cycle.
REQ-015 Misaligned: H/HU/SH with addr[0]=1, W with addr[1:0]!=0, or load func3 in {011,110,111} or store func3 >010: no bus request; next cycle o_wb_valid=1, o_misaligned=1, o_wb_we=0.
REQ-016 Aligned load/store accepted: IDLE->REQ; o_dmem_req=1, o_dmem_addr={addr[31:2],2'b00}, o_dmem_we=store, held stable until i_dmem_gnt.
REQ-017 Byte enables: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
REQ-018 Store data replicated: B -> {4{rs2[7:0]}}, H -> {2{rs2[15:0]}}, W -> rs2.
REQ-019 Store in REQ with gnt: o_dmem_req drops next cycle; o_wb_valid=1, o_wb_we=0 next cycle; ->IDLE.
REQ-020 Load in REQ with gnt: ->WAIT_RD, o_dmem_req=0; wait unbounded for i_dmem_rvalid.
REQ-021 Load data: select byte/half by latched addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged; result registered: o_wb_valid=1, o_wb_we=(rd!=0) cycle after rvalid; ->IDLE.
REQ-022 rvalid coincident with gnt in REQ is not permitted by the bus; rvalid in IDLE or REQ ignored.
REQ-023 o_wb_valid is a one-cycle pulse per accepted entry; WB never back-pressures.
REQ-024 Address, func3, rd, store data latched at accept; input changes during REQ/WAIT_RD ignored.

Reset
REQ-025 i_reset: state IDLE; o_dmem_req, o_dmem_we, o_wb_valid, o_wb_we, o_misaligned = 0; o_dmem_addr, o_dmem_be, o_dmem_wdata, o_wb_data, o_wb_rd = 0; o_ready = 1 the cycle after.
REQ-026 Reset mid-operation aborts the access with no o_wb_valid; a later stale rvalid is ignored.

Structure
REQ-027 PipelineReg package holds MEM_STATE/WB_STATE structs, the FSM state enum and func3 size constants.
REQ-028 Sub-module load_align (combinational: rdata, addr[1:0], func3 -> 32-bit extended value).

Verification
REQ-029 Pass-through ALUOutput=0x0000_1234, rd=5 -> next cycle o_wb_valid=1, data 0x1234, we=1; 3 back-to-back all complete.
REQ-030 SB addr 0x103, rs2 0xAB, gnt after 2 cycles -> addr 0x100, be 1000, wdata 0xABABABAB held 3 cycles; wb_valid, we=0.
REQ-031 LB addr 0x101, rdata 0x0000_8000 -> wb_data 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-032 LH addr 0x202, rdata 0xFFFE_0000, rvalid 4 cycles after gnt -> wb_data 0xFFFF_FFFE; o_ready 0 throughout.
REQ-033 LW addr 0x102 -> no o_dmem_req; next cycle o_misaligned=1, we=0.
REQ-034 Reset in WAIT_RD, then rvalid -> no o_wb_valid, state IDLE, o_ready=1.
